// File: rtl/cla_pipe_adder.sv
// Pipelined carry-lookahead adder/subtractor: one WIDTH/STAGES slice per stage,
// slice carry registered between stages, valid/ready handshake with full-pipe stall.
module cla_pipe_adder #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 2
) (
    input  logic             i_clk,
    input  logic             i_rstn,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic             i_c,
    input  logic             i_sub,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [WIDTH-1:0] o_s,
    output logic             o_c,
    output logic             o_ovf,
    output logic             o_zero
);

    localparam int SW = WIDTH / STAGES;
    localparam int NG = SW / 4;

    // Returns the carry into every bit of a slice plus the slice carry-out in
    // the top bit. Group carries are sum-of-products over all lower groups, so
    // no carry ripples across more than one group boundary.
    function automatic logic [SW:0] slice_carries(
        input logic [SW-1:0] x,
        input logic [SW-1:0] y,
        input logic          cin
    );
        logic [SW-1:0] p;
        logic [SW-1:0] g;
        logic [NG-1:0] gp;
        logic [NG-1:0] gg;
        logic [NG:0]   gc;
        logic [SW:0]   c;
        logic          term;
        logic          acc;
        p = x ^ y;
        g = x & y;
        for (int j = 0; j < NG; j++) begin
            gp[j] = &p[4*j +: 4];
            gg[j] = g[4*j+3]
                  | (p[4*j+3] & g[4*j+2])
                  | (p[4*j+3] & p[4*j+2] & g[4*j+1])
                  | (p[4*j+3] & p[4*j+2] & p[4*j+1] & g[4*j]);
        end
        for (int j = 0; j <= NG; j++) begin
            acc = cin;
            for (int m = 0; m < j; m++) acc = acc & gp[m];
            for (int i = 0; i < j; i++) begin
                term = gg[i];
                for (int m = i + 1; m < j; m++) term = term & gp[m];
                acc = acc | term;
            end
            gc[j] = acc;
        end
        for (int j = 0; j < NG; j++) begin
            for (int b = 0; b < 4; b++) begin
                acc = gc[j];
                for (int m = 0; m < b; m++) acc = acc & p[4*j+m];
                for (int i = 0; i < b; i++) begin
                    term = g[4*j+i];
                    for (int m = i + 1; m < b; m++) term = term & p[4*j+m];
                    acc = acc | term;
                end
                c[4*j+b] = acc;
            end
        end
        c[SW] = gc[NG];
        return c;
    endfunction

    logic [STAGES-1:0] vld_q, vld_d;
    logic [STAGES-1:0] cy_q, cy_d;
    logic [WIDTH-1:0]  a_q [STAGES];
    logic [WIDTH-1:0]  a_d [STAGES];
    logic [WIDTH-1:0]  b_q [STAGES];
    logic [WIDTH-1:0]  b_d [STAGES];
    logic [WIDTH-1:0]  s_q [STAGES];
    logic [WIDTH-1:0]  s_d [STAGES];
    logic              ovf_q, ovf_d;
    logic              zero_q, zero_d;

    logic [WIDTH-1:0]  in_a [STAGES];
    logic [WIDTH-1:0]  in_b [STAGES];
    logic [WIDTH-1:0]  in_s [STAGES];
    logic [STAGES-1:0] in_v;
    logic [STAGES-1:0] in_c;
    logic              en;

    assign en      = ~vld_q[STAGES-1] | i_ready;
    assign o_ready = en;

    // B is inverted once here; later stages only see the already-inverted value.
    assign in_a[0] = i_a;
    assign in_b[0] = i_sub ? ~i_b : i_b;
    assign in_s[0] = '0;
    assign in_v[0] = i_valid;
    assign in_c[0] = i_sub | i_c;

    genvar gi;
    generate
        for (gi = 1; gi < STAGES; gi++) begin : g_link
            assign in_a[gi] = a_q[gi-1];
            assign in_b[gi] = b_q[gi-1];
            assign in_s[gi] = s_q[gi-1];
            assign in_v[gi] = vld_q[gi-1];
            assign in_c[gi] = cy_q[gi-1];
        end
    endgenerate

    always_comb begin
        logic [SW:0]      cv;
        logic [WIDTH-1:0] sum_v;
        ovf_d  = 1'b0;
        zero_d = 1'b0;
        vld_d  = in_v;
        cy_d   = '0;
        for (int k = 0; k < STAGES; k++) begin
            cv    = slice_carries(in_a[k][k*SW +: SW], in_b[k][k*SW +: SW], in_c[k]);
            sum_v = in_s[k];
            sum_v[k*SW +: SW] = in_a[k][k*SW +: SW] ^ in_b[k][k*SW +: SW] ^ cv[SW-1:0];
            a_d[k]  = in_a[k];
            b_d[k]  = in_b[k];
            s_d[k]  = sum_v;
            cy_d[k] = cv[SW];
            if (k == STAGES - 1) begin
                ovf_d  = cv[SW] ^ cv[SW-1];
                zero_d = ~|sum_v;
            end
        end
    end

    // A stall freezes every stage at once, so bubbles are never squeezed out.
    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            vld_q  <= '0;
            cy_q   <= '0;
            ovf_q  <= 1'b0;
            zero_q <= 1'b0;
            for (int k = 0; k < STAGES; k++) begin
                a_q[k] <= '0;
                b_q[k] <= '0;
                s_q[k] <= '0;
            end
        end else if (en) begin
            vld_q  <= vld_d;
            cy_q   <= cy_d;
            ovf_q  <= ovf_d;
            zero_q <= zero_d;
            for (int k = 0; k < STAGES; k++) begin
                a_q[k] <= a_d[k];
                b_q[k] <= b_d[k];
                s_q[k] <= s_d[k];
            end
        end
    end

    assign o_valid = vld_q[STAGES-1];
    assign o_s     = s_q[STAGES-1];
    assign o_c     = cy_q[STAGES-1];
    assign o_ovf   = ovf_q;
    assign o_zero  = zero_q;

endmodule

// File: tb/tb_cla_pipe_adder.sv
// Bench for cla_pipe_adder: three configurations (32/2, 16/1, 64/4) checked
// against an arithmetic reference model through per-DUT expectation queues.
module tb_cla_pipe_adder;

    localparam int N = 3;

    typedef struct packed {
        logic [63:0] s;
        logic        c;
        logic        ovf;
        logic        zero;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rstn   [N];
    logic        vin    [N];
    logic        c_s    [N];
    logic        sub_s  [N];
    logic        rdy_in [N];
    logic        rmode  [N];
    logic [63:0] a_s    [N];
    logic [63:0] b_s    [N];
    logic [63:0] os     [N];
    logic        ordy   [N];
    logic        ov     [N];
    logic        oc     [N];
    logic        oovf   [N];
    logic        oz     [N];
    logic [31:0] s0;
    logic [15:0] s1;
    logic [63:0] s2;

    int n_cmp = 0;
    int n_err = 0;
    int n_in  [N];
    int n_out [N];
    int base0;

    assign os[0] = {32'b0, s0};
    assign os[1] = {48'b0, s1};
    assign os[2] = s2;

    cla_pipe_adder #(.WIDTH(32), .STAGES(2)) dut0 (
        .i_clk(clk), .i_rstn(rstn[0]), .i_valid(vin[0]), .o_ready(ordy[0]),
        .i_a(a_s[0][31:0]), .i_b(b_s[0][31:0]), .i_c(c_s[0]), .i_sub(sub_s[0]),
        .o_valid(ov[0]), .i_ready(rdy_in[0]), .o_s(s0), .o_c(oc[0]),
        .o_ovf(oovf[0]), .o_zero(oz[0]));

    cla_pipe_adder #(.WIDTH(16), .STAGES(1)) dut1 (
        .i_clk(clk), .i_rstn(rstn[1]), .i_valid(vin[1]), .o_ready(ordy[1]),
        .i_a(a_s[1][15:0]), .i_b(b_s[1][15:0]), .i_c(c_s[1]), .i_sub(sub_s[1]),
        .o_valid(ov[1]), .i_ready(rdy_in[1]), .o_s(s1), .o_c(oc[1]),
        .o_ovf(oovf[1]), .o_zero(oz[1]));

    cla_pipe_adder #(.WIDTH(64), .STAGES(4)) dut2 (
        .i_clk(clk), .i_rstn(rstn[2]), .i_valid(vin[2]), .o_ready(ordy[2]),
        .i_a(a_s[2]), .i_b(b_s[2]), .i_c(c_s[2]), .i_sub(sub_s[2]),
        .o_valid(ov[2]), .i_ready(rdy_in[2]), .o_s(s2), .o_c(oc[2]),
        .o_ovf(oovf[2]), .o_zero(oz[2]));

    function automatic int wof(int i);
        return (i == 0) ? 32 : (i == 1) ? 16 : 64;
    endfunction

    function automatic logic [63:0] mask(int w);
        return (w == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << w) - 64'd1);
    endfunction

    function automatic logic signed [67:0] sx(logic [63:0] x, int w);
        logic [67:0] r;
        r = {4'b0, x & mask(w)};
        if (x[w-1]) r = r | ~{4'b0, mask(w)};
        return $signed(r);
    endfunction

    // Reference: unsigned sum for s/c, true signed arithmetic for overflow.
    function automatic exp_t model(logic [63:0] a, logic [63:0] b, logic c, logic sub, int w);
        exp_t r;
        logic [64:0] full;
        logic [63:0] m, am, bm;
        logic signed [67:0] res, lim;
        m  = mask(w);
        am = a & m;
        bm = b & m;
        if (sub) full = {1'b0, am} + {1'b0, ~bm & m} + 65'd1;
        else     full = {1'b0, am} + {1'b0, bm} + {64'b0, c};
        r.s  = full[63:0] & m;
        r.c  = full[w];
        if (sub) res = sx(am, w) - sx(bm, w);
        else     res = sx(am, w) + sx(bm, w) + (c ? 68'sd1 : 68'sd0);
        lim    = 68'sd1 <<< (w - 1);
        r.ovf  = (res >= lim) || (res < -lim);
        r.zero = (r.s == 64'd0);
        return r;
    endfunction

    function automatic logic [63:0] rnd(int w);
        logic [63:0] m;
        m = mask(w);
        case ($urandom % 6)
            0:       return 64'd0;
            1:       return m;
            2:       return (m >> 1) + 64'd1;
            3:       return m >> 1;
            4:       return 64'd1;
            default: return {$urandom, $urandom} & m;
        endcase
    endfunction

    task automatic check(input string name, input logic [67:0] got, input logic [67:0] expv);
        n_cmp++;
        if (got !== expv) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, got, expv);
        end
    endtask

    task automatic send(int i, logic [63:0] a, logic [63:0] b, logic c, logic sub);
        int t;
        vin[i]   = 1'b1;
        a_s[i]   = a;
        b_s[i]   = b;
        c_s[i]   = c;
        sub_s[i] = sub;
        #1;
        t = 0;
        while (!ordy[i] && t < 500) begin
            @(negedge clk);
            #1;
            t++;
        end
        if (!ordy[i]) check($sformatf("accept_timeout%0d", i), 68'(ordy[i]), 68'd1);
        @(negedge clk);
        vin[i] = 1'b0;
    endtask

    task automatic drain(int i);
        int t;
        t = 0;
        while (n_out[i] != n_in[i] && t < 3000) begin
            @(negedge clk);
            t++;
        end
        check($sformatf("drain%0d", i), 68'(n_out[i]), 68'(n_in[i]));
    endtask

    task automatic run_random(int i, int nvec);
        int w;
        w = wof(i);
        for (int k = 0; k < nvec; k++) begin
            if ($urandom % 4 == 0) @(negedge clk);
            send(i, rnd(w), rnd(w), 1'($urandom % 2), 1'($urandom % 2));
        end
    endtask

    // Literal latency (2 cycles) and result check on the 32/2 instance.
    task automatic directed(string name, logic [31:0] a, logic [31:0] b, logic c, logic sub,
                            logic [31:0] es, logic ec, logic eo, logic ez);
        send(0, {32'b0, a}, {32'b0, b}, c, sub);
        #1;
        check({name, "_early"}, 68'(ov[0]), 68'd0);
        @(negedge clk);
        #1;
        check(name, 68'({ov[0], os[0][31:0], oc[0], oovf[0], oz[0]}), 68'({1'b1, es, ec, eo, ez}));
        @(negedge clk);
    endtask

    initial begin
        forever begin
            @(negedge clk);
            for (int i = 0; i < N; i++)
                rdy_in[i] = rmode[i] ? 1'($urandom % 3 != 0) : 1'b1;
        end
    end

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_mon
            exp_t        q[$];
            exp_t        e;
            logic        held = 1'b0;
            logic [67:0] hv;
            always @(negedge clk) begin
                #2;
                if (!rstn[gi]) begin
                    q.delete();
                    held = 1'b0;
                    n_in[gi] = n_out[gi];
                end else begin
                    if (held)
                        check($sformatf("hold%0d", gi),
                              {ov[gi], os[gi], oc[gi], oovf[gi], oz[gi]}, hv);
                    check($sformatf("ready%0d", gi), 68'(ordy[gi]), 68'(!ov[gi] || rdy_in[gi]));
                    if (ov[gi] && rdy_in[gi]) begin
                        if (q.size() == 0) begin
                            check($sformatf("spurious%0d", gi), 68'(ov[gi]), 68'd0);
                        end else begin
                            e = q.pop_front();
                            n_out[gi]++;
                            $display("dut%0d out #%0d s=%h c=%b ovf=%b zero=%b", gi, n_out[gi],
                                     os[gi], oc[gi], oovf[gi], oz[gi]);
                            check($sformatf("result%0d", gi),
                                  68'({os[gi], oc[gi], oovf[gi], oz[gi]}), 68'(e));
                        end
                    end
                    if (vin[gi] && ordy[gi]) begin
                        q.push_back(model(a_s[gi], b_s[gi], c_s[gi], sub_s[gi], wof(gi)));
                        n_in[gi]++;
                    end
                    held = ov[gi] && !rdy_in[gi];
                    hv   = {ov[gi], os[gi], oc[gi], oovf[gi], oz[gi]};
                end
            end
        end
    endgenerate

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < N; i++) begin
            rstn[i] = 1'b0; vin[i] = 1'b0; c_s[i] = 1'b0; sub_s[i] = 1'b0;
            rdy_in[i] = 1'b1; rmode[i] = 1'b0; a_s[i] = '0; b_s[i] = '0;
            n_in[i] = 0; n_out[i] = 0;
        end

        check("model_pin_add",   68'(model(64'h1, 64'h2, 1'b1, 1'b0, 32)), {64'h4, 3'b000});
        check("model_pin_sub",   68'(model(64'h8000_0000, 64'h1, 1'b0, 1'b1, 32)), {64'h7FFF_FFFF, 3'b110});
        check("model_pin_wrap",  68'(model(64'hFFFF, 64'h1, 1'b0, 1'b0, 16)), {64'h0, 3'b101});
        check("model_pin_sub64", 68'(model(64'h0, 64'h1, 1'b1, 1'b1, 64)), {64'hFFFF_FFFF_FFFF_FFFF, 3'b000});

        repeat (3) @(negedge clk);
        for (int i = 0; i < N; i++) rstn[i] = 1'b1;
        #1;
        for (int i = 0; i < N; i++)
            check($sformatf("reset_state%0d", i),
                  68'({ov[i], os[i], oc[i], oovf[i], oz[i], ordy[i]}), 68'(1'b1));
        @(negedge clk);

        fork
            begin
                directed("add_small",   32'h1, 32'h2, 1'b1, 1'b0, 32'h4, 1'b0, 1'b0, 1'b0);
                directed("carry_all",   32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b1);
                directed("carry_slice", 32'h0000_FFFF, 32'h1, 1'b0, 1'b0, 32'h0001_0000, 1'b0, 1'b0, 1'b0);
                directed("ovf_add",     32'h7FFF_FFFF, 32'h1, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 1'b0);
                directed("ovf_sub",     32'h8000_0000, 32'h1, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0);
                directed("sub_neg",     32'h5, 32'h7, 1'b1, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0);
                directed("sub_equal",   32'h1234, 32'h1234, 1'b0, 1'b1, 32'h0, 1'b1, 1'b0, 1'b1);

                base0 = n_out[0];
                rmode[0] = 1'b1;
                for (int j = 1; j <= 100; j++) send(0, 64'(j), 64'(2 * j), 1'b1, 1'b0);
                drain(0);
                check("stream_count", 68'(n_out[0] - base0), 68'd100);

                rmode[0] = 1'b0;
                @(negedge clk);
                send(0, 64'd10, 64'd20, 1'b0, 1'b0);
                send(0, 64'd30, 64'd40, 1'b0, 1'b0);
                rstn[0] = 1'b0;
                @(negedge clk);
                rstn[0] = 1'b1;
                #1;
                check("reset_mid", 68'({ov[0], os[0], oc[0], oovf[0], oz[0]}), 68'd0);
                for (int k = 0; k < 5; k++) begin
                    @(negedge clk);
                    #1;
                    check("post_reset_valid", 68'(ov[0]), 68'd0);
                end
                @(negedge clk);

                rmode[0] = 1'b1;
                run_random(0, 300);
                drain(0);
            end
            begin
                rmode[1] = 1'b1;
                run_random(1, 1000);
                drain(1);
            end
            begin
                rmode[2] = 1'b1;
                run_random(2, 1000);
                drain(2);
            end
        join

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
